// File: rtl/sensor_poll_seq.sv
// Sequencer in front of the I2C register controller: writes the sensor config once after
// enable, then issues a 6-byte burst read every POLL_CYCLES and unpacks two 18-bit samples.
module sensor_poll_seq #(
    parameter int unsigned POLL_CYCLES    = 25000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  DEV_ID         = 8'h80,
    parameter logic [15:0] CFG_ADDR       = 16'h0001,
    parameter logic [7:0]  CFG_DATA       = 8'h1C,
    parameter logic [15:0] DATA_ADDR      = 16'h0002,
    parameter logic        ADDR_MODE      = 1'b0
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        enable,
    output logic        wrreg_req,
    output logic        rdreg_req,
    output logic        lrdreg_req,
    output logic [15:0] addr,
    output logic        addr_mode,
    output logic [7:0]  wrdata,
    output logic [7:0]  device_id,
    input  logic        RW_Done,
    input  logic        LRW_Done,
    input  logic [47:0] l_rddata,
    input  logic        ack,
    output logic [17:0] ch0_value,
    output logic [17:0] ch1_value,
    output logic        data_valid,
    output logic        init_done,
    output logic        err_nack,
    output logic        err_timeout,
    output logic [15:0] sample_cnt
);

    localparam int unsigned MAX_CYC = (POLL_CYCLES > TIMEOUT_CYCLES) ? POLL_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] POLL_LAST = CW'(POLL_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_OFF         = 3'd0,
        S_CFG_REQ     = 3'd1,
        S_CFG_WAIT    = 3'd2,
        S_CFG_BACKOFF = 3'd3,
        S_POLL_WAIT   = 3'd4,
        S_RD_REQ      = 3'd5,
        S_RD_WAIT     = 3'd6
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   poll_r;
    logic [CW-1:0]   tmo_r;
    logic            fail_r;
    logic            poll_clr_s;
    logic            req_s;
    logic            tmo_hit_s;
    logic            set_nack_s;
    logic            good_rd_s;
    logic            init_set_s;
    logic            unused_bits_s;

    assign unused_bits_s = ^{l_rddata[47:42], l_rddata[23:18]};

    // Next-state decode and per-cycle event strobes
    always_comb begin
        state_nxt_s = state_r;
        poll_clr_s  = 1'b0;
        tmo_hit_s   = 1'b0;
        set_nack_s  = 1'b0;
        good_rd_s   = 1'b0;
        init_set_s  = 1'b0;
        case (state_r)
            S_OFF: begin
                if (enable) state_nxt_s = S_CFG_REQ;
                else        state_nxt_s = S_OFF;
            end
            S_CFG_REQ: state_nxt_s = S_CFG_WAIT;
            S_CFG_WAIT: begin
                if (RW_Done) begin
                    poll_clr_s = 1'b1;
                    set_nack_s = ack;
                    if (ack || fail_r) begin
                        state_nxt_s = S_CFG_BACKOFF;
                    end else if (enable) begin
                        init_set_s  = 1'b1;
                        state_nxt_s = S_POLL_WAIT;
                    end else begin
                        state_nxt_s = S_OFF;
                    end
                end else begin
                    tmo_hit_s = (tmo_r == TMO_LAST);
                end
            end
            S_CFG_BACKOFF: begin
                if (poll_r >= POLL_LAST) state_nxt_s = enable ? S_CFG_REQ : S_OFF;
                else                     state_nxt_s = S_CFG_BACKOFF;
            end
            S_POLL_WAIT: begin
                if (!enable)                  state_nxt_s = S_OFF;
                else if (poll_r >= POLL_LAST) state_nxt_s = S_RD_REQ;
                else                          state_nxt_s = S_POLL_WAIT;
            end
            S_RD_REQ: state_nxt_s = S_RD_WAIT;
            S_RD_WAIT: begin
                if (LRW_Done) begin
                    set_nack_s  = ack;
                    good_rd_s   = !ack && !fail_r;
                    state_nxt_s = enable ? S_POLL_WAIT : S_OFF;
                end else begin
                    tmo_hit_s = (tmo_r == TMO_LAST);
                end
            end
            default: state_nxt_s = S_OFF;
        endcase
        req_s = (state_nxt_s == S_CFG_REQ) || (state_nxt_s == S_RD_REQ);
    end

    // State register
    always_ff @(posedge Clk) begin
        if (!Rst_n) state_r <= S_OFF;
        else        state_r <= state_nxt_s;
    end

    // Poll and timeout counters; the poll timer restarts on the read request so the period is exact
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            poll_r <= CNT_ZERO;
            tmo_r  <= CNT_ZERO;
            fail_r <= 1'b0;
        end else begin
            if (poll_clr_s || state_nxt_s == S_RD_REQ) poll_r <= CNT_ZERO;
            else if (poll_r != CNT_MAX)                 poll_r <= poll_r + CNT_ONE;
            if (req_s)                tmo_r <= CNT_ZERO;
            else if (tmo_r != CNT_MAX) tmo_r <= tmo_r + CNT_ONE;
            if (req_s)          fail_r <= 1'b0;
            else if (tmo_hit_s) fail_r <= 1'b1;
        end
    end

    // Registered controller requests, samples and status flags
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wrreg_req   <= 1'b0;
            rdreg_req   <= 1'b0;
            lrdreg_req  <= 1'b0;
            addr        <= 16'h0000;
            wrdata      <= 8'h00;
            addr_mode   <= ADDR_MODE;
            device_id   <= DEV_ID;
            ch0_value   <= 18'h00000;
            ch1_value   <= 18'h00000;
            data_valid  <= 1'b0;
            init_done   <= 1'b0;
            err_nack    <= 1'b0;
            err_timeout <= 1'b0;
            sample_cnt  <= 16'h0000;
        end else begin
            wrreg_req  <= (state_nxt_s == S_CFG_REQ);
            rdreg_req  <= 1'b0;
            lrdreg_req <= (state_nxt_s == S_RD_REQ);
            addr_mode  <= ADDR_MODE;
            device_id  <= DEV_ID;
            if (state_nxt_s == S_CFG_REQ) begin
                addr   <= CFG_ADDR;
                wrdata <= CFG_DATA;
            end else if (state_nxt_s == S_RD_REQ) begin
                addr   <= DATA_ADDR;
            end
            data_valid <= good_rd_s;
            if (good_rd_s) begin
                ch0_value  <= {l_rddata[41:40], l_rddata[39:24]};
                ch1_value  <= {l_rddata[17:16], l_rddata[15:0]};
                sample_cnt <= sample_cnt + 16'd1;
            end
            if (init_set_s)                  init_done <= 1'b1;
            else if (state_nxt_s == S_OFF)   init_done <= 1'b0;
            err_nack    <= err_nack | set_nack_s;
            err_timeout <= err_timeout | tmo_hit_s;
        end
    end

endmodule

// File: tb/tb_sensor_poll_seq.sv
// Directed-sequence bench for sensor_poll_seq with a behavioural I2C controller responder
// and request/sample logs checked against schedule arithmetic.
module tb_sensor_poll_seq;

    localparam int P = 100;
    localparam int T = 50;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        RW_Done = 1'b0;
    logic        LRW_Done = 1'b0;
    logic        ack = 1'b0;
    logic [47:0] l_rddata = 48'h0;
    logic        wrreg_req, rdreg_req, lrdreg_req, addr_mode, data_valid;
    logic        init_done, err_nack, err_timeout;
    logic [15:0] addr, sample_cnt;
    logic [7:0]  wrdata, device_id;
    logic [17:0] ch0_value, ch1_value;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    // Responder configuration, captured per transaction when a request is seen
    int          rsp_lat = 20;
    logic        rsp_ack = 1'b0;
    logic [47:0] rsp_data = 48'h0;
    bit          busy = 1'b0;
    bit          busy_rd = 1'b0;
    int          due = 0;
    logic        cur_ack = 1'b0;
    logic [47:0] cur_data = 48'h0;
    int          overlap = 0;
    int          single_rd = 0;

    typedef struct { int c; logic [15:0] a; logic [7:0] d; } req_t;
    typedef struct { int c; logic [17:0] c0; logic [17:0] c1; logic [15:0] n; } dv_t;
    req_t wr_q[$];
    req_t rd_q[$];
    dv_t  dv_q[$];

    sensor_poll_seq #(.POLL_CYCLES(P), .TIMEOUT_CYCLES(T)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .enable(enable),
        .wrreg_req(wrreg_req), .rdreg_req(rdreg_req), .lrdreg_req(lrdreg_req),
        .addr(addr), .addr_mode(addr_mode), .wrdata(wrdata), .device_id(device_id),
        .RW_Done(RW_Done), .LRW_Done(LRW_Done), .l_rddata(l_rddata), .ack(ack),
        .ch0_value(ch0_value), .ch1_value(ch1_value), .data_valid(data_valid),
        .init_done(init_done), .err_nack(err_nack), .err_timeout(err_timeout),
        .sample_cnt(sample_cnt)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Controller model and event logger, acting on the falling edge
    always @(negedge Clk) begin
        RW_Done  = 1'b0;
        LRW_Done = 1'b0;
        ack      = 1'b0;
        l_rddata = {16'($urandom()), 32'($urandom())};
        if (rdreg_req) single_rd++;
        if (wrreg_req)  wr_q.push_back('{c: cyc, a: addr, d: wrdata});
        if (lrdreg_req) rd_q.push_back('{c: cyc, a: addr, d: wrdata});
        if (data_valid) dv_q.push_back('{c: cyc, c0: ch0_value, c1: ch1_value, n: sample_cnt});
        if (!Rst_n) begin
            busy = 1'b0;
        end else begin
            if ((wrreg_req || lrdreg_req) && busy) overlap++;
            if (busy && cyc == due) begin
                if (busy_rd) begin
                    LRW_Done = 1'b1;
                    l_rddata = cur_data;
                end else begin
                    RW_Done = 1'b1;
                end
                ack  = cur_ack;
                busy = 1'b0;
            end
            if (wrreg_req || lrdreg_req) begin
                busy     = 1'b1;
                busy_rd  = lrdreg_req;
                due      = cyc + rsp_lat;
                cur_ack  = rsp_ack;
                cur_data = rsp_data;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge Clk);
            #1;
        end
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) tick(1);
    endtask

    function automatic int qsize(input int sel);
        case (sel)
            0:       return wr_q.size();
            1:       return rd_q.size();
            default: return dv_q.size();
        endcase
    endfunction

    task automatic wait_for(input int sel, input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (qsize(sel) < n && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 64'(qsize(sel) >= n), 64'd1);
    endtask

    initial begin
        int r, e, rd0, rc, c5, w1, w2, c6;
        logic [47:0] d;
        int exp_cnt;
        exp_cnt = 0;

        // Reset values
        Rst_n = 1'b0;
        enable = 1'b0;
        tick(3);
        check("rst_ctrl", 64'({wrreg_req, rdreg_req, lrdreg_req, data_valid, init_done, err_nack, err_timeout}), 64'd0);
        check("rst_addr_data", 64'({addr, wrdata}), 64'd0);
        check("rst_ids", 64'({addr_mode, device_id}), 64'h080);
        check("rst_samples", 64'({ch0_value, ch1_value, sample_cnt}), 64'd0);
        Rst_n = 1'b1;
        tick(5);
        check("off_idle", 64'(wr_q.size() + rd_q.size()), 64'd0);

        // Config write accepted
        rsp_lat = 20;
        rsp_ack = 1'b0;
        e = cyc;
        enable = 1'b1;
        wait_for(0, 1, 10, "cfg_req_seen");
        r = wr_q[0].c;
        check("cfg_req_cycle", 64'(r), 64'(e + 1));
        check("cfg_addr", 64'(wr_q[0].a), 64'h0001);
        check("cfg_data", 64'(wr_q[0].d), 64'h1C);
        goto_cyc(r + 1);
        check("cfg_pulse_len", 64'(wrreg_req), 64'd0);
        goto_cyc(r + 20);
        check("init_before_done", 64'(init_done), 64'd0);
        goto_cyc(r + 21);
        check("init_after_done", 64'(init_done), 64'd1);

        // Three good polls
        rsp_lat = 10;
        d = 48'h03_ABCD_01_1234;
        rd0 = 0;
        for (int i = 0; i < 3; i++) begin
            rsp_data = d;
            wait_for(1, i + 1, 2 * P, "rd_req_seen");
            if (i == 0) begin
                rd0 = rd_q[0].c;
                check("rd_first_cycle", 64'(rd0), 64'(r + 20 + P + 1));
            end else begin
                check("rd_period", 64'(rd_q[i].c), 64'(rd0 + P * i));
            end
            check("rd_addr", 64'(rd_q[i].a), 64'h0002);
            wait_for(2, i + 1, 40, "dv_seen");
            exp_cnt++;
            check("dv_cycle", 64'(dv_q[i].c), 64'(rd_q[i].c + 11));
            check("ch0", 64'(dv_q[i].c0), 64'((d >> 24) % 48'd262144));
            check("ch1", 64'(dv_q[i].c1), 64'(d % 48'd262144));
            check("sample_cnt", 64'(dv_q[i].n), 64'(exp_cnt));
            goto_cyc(dv_q[i].c + 1);
            check("dv_pulse_len", 64'(data_valid), 64'd0);
            d = {16'($urandom()), 32'($urandom())};
        end

        // Read that times out, then the next one back on schedule
        rsp_data = d;
        rsp_lat = 80;
        wait_for(1, 4, 2 * P, "tmo_rd_seen");
        rc = rd_q[3].c;
        check("tmo_rd_cycle", 64'(rc), 64'(rd0 + 3 * P));
        rsp_lat = 10;
        d = {16'($urandom()), 32'($urandom())};
        rsp_data = d;
        goto_cyc(rc + T - 1);
        check("tmo_not_yet", 64'(err_timeout), 64'd0);
        goto_cyc(rc + T);
        check("tmo_flag", 64'(err_timeout), 64'd1);
        goto_cyc(rc + 85);
        check("tmo_no_dv", 64'(dv_q.size()), 64'd3);
        check("tmo_cnt_hold", 64'(sample_cnt), 64'd3);
        wait_for(1, 5, 2 * P, "post_tmo_rd_seen");
        check("post_tmo_rd_cycle", 64'(rd_q[4].c), 64'(rc + P));
        wait_for(2, 4, 40, "post_tmo_dv_seen");
        exp_cnt++;
        check("post_tmo_ch0", 64'(dv_q[3].c0), 64'((d >> 24) % 48'd262144));
        check("post_tmo_cnt", 64'(dv_q[3].n), 64'(exp_cnt));

        // Disable during a read: it completes, then everything stops
        d = {16'($urandom()), 32'($urandom())};
        rsp_data = d;
        rsp_lat = 30;
        wait_for(1, 6, 2 * P, "dis_rd_seen");
        c5 = rd_q[5].c;
        check("dis_rd_cycle", 64'(c5), 64'(rc + 2 * P));
        goto_cyc(c5 + 5);
        enable = 1'b0;
        wait_for(2, 5, 60, "dis_dv_seen");
        exp_cnt++;
        check("dis_dv_cycle", 64'(dv_q[4].c), 64'(c5 + 31));
        check("dis_ch1", 64'(dv_q[4].c1), 64'(d % 48'd262144));
        check("dis_cnt", 64'(dv_q[4].n), 64'(exp_cnt));
        goto_cyc(c5 + 300);
        check("dis_no_reqs", 64'({16'(wr_q.size()), 16'(rd_q.size())}), 64'h0001_0006);
        check("dis_init_clr", 64'(init_done), 64'd0);

        // Re-enable: config write NACKed, retried after the backoff
        rsp_ack = 1'b1;
        rsp_lat = 20;
        e = cyc;
        enable = 1'b1;
        wait_for(0, 2, 10, "recfg_seen");
        w1 = wr_q[1].c;
        check("recfg_cycle", 64'(w1), 64'(e + 1));
        rsp_ack = 1'b0;
        goto_cyc(w1 + 21);
        check("nack_flag", 64'({err_nack, init_done, err_timeout}), 64'b101);
        wait_for(0, 3, 2 * P, "retry_seen");
        w2 = wr_q[2].c;
        check("retry_cycle", 64'(w2), 64'(w1 + 20 + P + 1));
        check("retry_addr", 64'({wr_q[2].a, wr_q[2].d}), 64'h0001_1C);
        goto_cyc(w2 + 21);
        check("retry_init", 64'({init_done, err_nack}), 64'b11);

        // One-cycle reset in the middle of a read
        rsp_lat = 40;
        wait_for(1, 7, 2 * P, "rst_rd_seen");
        c6 = rd_q[6].c;
        check("rst_rd_cycle", 64'(c6), 64'(w2 + 20 + P + 1));
        goto_cyc(c6 + 5);
        Rst_n = 1'b0;
        enable = 1'b0;
        tick(1);
        check("mid_rst_flags", 64'({err_nack, err_timeout, init_done, data_valid, wrreg_req, lrdreg_req}), 64'd0);
        check("mid_rst_samples", 64'({ch0_value, ch1_value, sample_cnt}), 64'd0);
        check("mid_rst_ids", 64'({addr, device_id, addr_mode}), 64'({16'h0000, 8'h80, 1'b0}));
        Rst_n = 1'b1;
        goto_cyc(c6 + 60);
        check("post_rst_idle", 64'({16'(wr_q.size()), 16'(rd_q.size()), 16'(dv_q.size())}), 64'h0003_0007_0005);
        rsp_lat = 20;
        e = cyc;
        enable = 1'b1;
        wait_for(0, 4, 10, "post_rst_cfg_seen");
        check("post_rst_cfg_cycle", 64'(wr_q[3].c), 64'(e + 1));
        goto_cyc(wr_q[3].c + 21);
        check("post_rst_init", 64'(init_done), 64'd1);
        check("no_overlap", 64'(overlap), 64'd0);
        check("rdreg_never", 64'(single_rd), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
